// File: rtl/hs_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hs_pkg
// Description : Types and constants shared by the handshake skid slice.
//               Holds the slice state encoding and the default payload width.
// Revision    : 1.0  initial release
// ============================================================================
package hs_pkg;

  // Default payload width for the slice.
  localparam int HS_DATA_W = 32;

  // Slice occupancy: no word, one word in main, two words (main + skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } hs_state_e;

endpackage : hs_pkg
`default_nettype wire

// File: rtl/hs_skid_slice.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hs_skid_slice
// Description : Fully registered valid/ready pipeline slice (depth-2 skid
//               buffer). Every output comes straight from a flop, so no
//               combinational path exists between the upstream and the
//               downstream side. Sustains one word per cycle; a single skid
//               register absorbs the word accepted in the cycle a stall
//               starts. A wrapping counter tallies downstream transfers.
// Revision    : 1.0  initial release
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   s_data     in   DATA_W  payload from upstream master
//   s_valid    in   1       upstream word valid
//   s_ready    out  1       slice can accept (registered)
//   m_data     out  DATA_W  payload to downstream slave (registered)
//   m_valid    out  1       downstream word valid (registered)
//   m_ready    in   1       downstream accepts
//   xfer_count out  CNT_W   completed downstream transfers, mod 2^CNT_W
// ============================================================================
module hs_skid_slice
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  xfer_count
);

  hs_state_e          state_q, state_d;
  logic [DATA_W-1:0]  main_q,  main_d;
  logic [DATA_W-1:0]  skid_q,  skid_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               up_xfer;
  logic               dn_xfer;

  // Handshakes are evaluated against the registered ready/valid, so a word
  // offered while s_ready is still low after reset is never taken.
  assign up_xfer = s_valid & s_ready_q;
  assign dn_xfer = m_valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (up_xfer) begin
          main_d  = s_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (up_xfer && dn_xfer) begin
          // Outgoing word leaves as the new one lands in main.
          main_d = s_data;
        end else if (up_xfer) begin
          // Stall began this cycle: park the extra word in skid.
          skid_d  = s_data;
          state_d = ST_FULL;
        end else if (dn_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // s_ready is low here, so s_valid cannot cause a transfer.
        if (dn_xfer) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (dn_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Handshake outputs are registered copies of the next occupancy.
    s_ready_d = (state_d != ST_FULL);
    m_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_data     = main_q;
  assign xfer_count = cnt_q;

endmodule : hs_skid_slice
`default_nettype wire

// File: tb/tb_hs_skid_slice.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hs_skid_slice
// Description : Self-checking bench for hs_skid_slice: reset behaviour,
//               streaming, stall/skid table, counter wrap, randomised
//               traffic with a scoreboard, and reset while full.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hs_skid_slice;
  import hs_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [CNT_W-1:0]  xfer_count;

  hs_skid_slice #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive inputs at the falling edge, then sample 1 unit after the next rise.
  task automatic step(input logic sv, input logic [31:0] d, input logic mr);
    @(negedge clk);
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sv;
    logic        mr;
    logic [31:0] d;
    logic [1:0]  st;
    logic        srdy;
    logic        mv;
    logic [31:0] md;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [9];

  logic [31:0] sb [$];
  logic [31:0] exp_w;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [15:0] base_cnt;
  int          pops;

  initial begin
    // Stall / skid sequence, starting EMPTY with xfer_count = 16.
    vecs[0] = '{1'b1, 1'b0, 32'hA5A5A5A5, ST_BUSY,  1'b1, 1'b1, 32'hA5A5A5A5, 16'd16};
    vecs[1] = '{1'b1, 1'b0, 32'h5A5A5A5A, ST_FULL,  1'b0, 1'b1, 32'hA5A5A5A5, 16'd16};
    vecs[2] = '{1'b1, 1'b0, 32'hFFFFFFFF, ST_FULL,  1'b0, 1'b1, 32'hA5A5A5A5, 16'd16};
    vecs[3] = '{1'b0, 1'b1, 32'h00000000, ST_BUSY,  1'b1, 1'b1, 32'h5A5A5A5A, 16'd17};
    vecs[4] = '{1'b0, 1'b1, 32'h00000000, ST_EMPTY, 1'b1, 1'b0, 32'h5A5A5A5A, 16'd18};
    vecs[5] = '{1'b1, 1'b1, 32'h11111111, ST_BUSY,  1'b1, 1'b1, 32'h11111111, 16'd18};
    vecs[6] = '{1'b1, 1'b1, 32'h22222222, ST_BUSY,  1'b1, 1'b1, 32'h22222222, 16'd19};
    vecs[7] = '{1'b0, 1'b0, 32'h33333333, ST_BUSY,  1'b1, 1'b1, 32'h22222222, 16'd19};
    vecs[8] = '{1'b0, 1'b1, 32'h00000000, ST_EMPTY, 1'b1, 1'b0, 32'h22222222, 16'd20};

    // ---------------- reset with s_valid held high ----------------
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hCAFEF00D;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.s_ready",    s_ready,    0);
    chk("rst.m_valid",    m_valid,    0);
    chk("rst.m_data",     m_data,     0);
    chk("rst.xfer_count", xfer_count, 0);
    chk("rst.state",      dut.state_q, ST_EMPTY);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.s_ready", s_ready, 1);
    chk("rel.m_valid", m_valid, 0);

    // ---------------- stream 1..16 with m_ready = 1 ----------------
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 32'(i), 1'b1);
      chk($sformatf("stream%0d.m_valid", i), m_valid, 1);
      chk($sformatf("stream%0d.m_data", i),  m_data,  i);
      chk($sformatf("stream%0d.count", i),   xfer_count, i - 1);
    end
    step(1'b0, 32'h0, 1'b1);
    chk("stream.drain.m_valid", m_valid, 0);
    chk("stream.count",         xfer_count, 16);

    // ---------------- table-driven stall / skid vectors ----------------
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].sv, vecs[i].d, vecs[i].mr);
      chk($sformatf("vec%0d.state", i),   dut.state_q, vecs[i].st);
      chk($sformatf("vec%0d.s_ready", i), s_ready,     vecs[i].srdy);
      chk($sformatf("vec%0d.m_valid", i), m_valid,     vecs[i].mv);
      chk($sformatf("vec%0d.m_data", i),  m_data,      vecs[i].md);
      chk($sformatf("vec%0d.count", i),   xfer_count,  vecs[i].cnt);
    end

    // ---------------- counter wrap ----------------
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    step(1'b1, 32'h0000_0101, 1'b1);
    chk("wrap.pre", xfer_count, 16'hFFFE);
    step(1'b1, 32'h0000_0102, 1'b1);
    chk("wrap.1", xfer_count, 16'hFFFF);
    step(1'b1, 32'h0000_0103, 1'b1);
    chk("wrap.2", xfer_count, 16'h0000);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap.3", xfer_count, 16'h0001);
    chk("wrap.empty", m_valid, 0);

    // ---------------- random traffic with late s_valid ----------------
    sb.delete();
    pops       = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    base_cnt   = xfer_count;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1.1;
      s_valid = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      m_ready = ($urandom_range(0, 3) != 0);
      if (prev_stall) begin
        chk("rand.stall.m_valid", m_valid, 1);
        chk("rand.stall.m_data",  m_data,  prev_data);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("rand.unexpected_word", m_data, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_w = sb.pop_front();
          chk("rand.order", m_data, exp_w);
        end
        pops++;
      end
      if (s_valid && s_ready) sb.push_back(s_data);
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
    end
    @(posedge clk);
    #1;
    chk("rand.count", xfer_count, 16'(base_cnt + 16'(pops)));
    chk("rand.occupancy", ((sb.size() == 0) ? 1'b0 : 1'b1), m_valid);

    // ---------------- reset asserted while FULL ----------------
    repeat (3) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h1234_5678, 1'b0);
    step(1'b1, 32'h8765_4321, 1'b0);
    chk("full.state", dut.state_q, ST_FULL);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.s_ready",    s_ready,    0);
    chk("arst.m_valid",    m_valid,    0);
    chk("arst.m_data",     m_data,     0);
    chk("arst.xfer_count", xfer_count, 0);
    chk("arst.skid",       dut.skid_q, 0);
    chk("arst.state",      dut.state_q, ST_EMPTY);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    m_ready = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    chk("post.s_ready", s_ready, 1);
    chk("post.m_valid", m_valid, 0);
    step(1'b1, 32'hDEADBEEF, 1'b0);
    chk("post.m_valid1", m_valid, 1);
    chk("post.m_data",   m_data,  32'hDEADBEEF);
    step(1'b0, 32'h0, 1'b1);
    chk("post.alone",   m_valid,    0);
    chk("post.count",   xfer_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hs_skid_slice
`default_nettype wire
